// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seq_restoring_divider_rcas.sv
// N-bit ripple-carry adder/subtractor; in subtract mode c_out reports borrow.
module RCAS_Nbit #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         add_sub,
  output logic [N-1:0] sum,
  output logic         c_out
);

  logic [N:0]   carry;
  logic [N-1:0] b_eff;

  // Subtraction is a + ~b + 1; the final carry is inverted so that a set c_out means a < b.
  always_comb begin
    carry    = '0;
    sum      = '0;
    b_eff    = b ^ {N{add_sub}};
    carry[0] = add_sub;
    for (int i = 0; i < N; i++) begin
      sum[i]       = a[i] ^ b_eff[i] ^ carry[i];
      carry[i + 1] = (a[i] & b_eff[i]) | (carry[i] & (a[i] ^ b_eff[i]));
    end
    c_out = carry[N] ^ add_sub;
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider with valid/ready handshakes on both sides.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = cnt_width(N);

  div_state_t state_q, state_d;
  logic [N-1:0] q_q, q_d;
  logic [N:0]   d_q, d_d;
  logic [N:0]   r_q, r_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0] quotient_q, quotient_d;
  logic [N-1:0] remainder_q, remainder_d;
  logic         dbz_q, dbz_d;

  logic [N:0] rs;
  logic [N:0] diff;
  logic       borrow;

  // The remainder msb is never needed to form the next shifted remainder.
  logic unused_r_msb;
  assign unused_r_msb = r_q[N];

  assign rs = {r_q[N-1:0], q_q[N-1]};

  RCAS_Nbit #(.N(N + 1)) u_rcas (
    .a       (rs),
    .b       (d_q),
    .add_sub (1'b1),
    .sum     (diff),
    .c_out   (borrow)
  );

  always_comb begin
    state_d     = state_q;
    q_d         = q_q;
    d_d         = d_q;
    r_d         = r_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          q_d   = dividend;
          d_d   = {1'b0, divisor};
          r_d   = '0;
          cnt_d = CW'(N);
          if (divisor == '0) begin
            state_d     = DONE;
            q_d         = '1;
            r_d         = {1'b0, dividend};
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
          end else begin
            state_d = BUSY;
            dbz_d   = 1'b0;
          end
        end
      end
      BUSY: begin
        if (!borrow) begin
          r_d = diff;
          q_d = {q_q[N-2:0], 1'b1};
        end else begin
          r_d = rs;
          q_d = {q_q[N-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        // The result registers load on the final iteration so they stay frozen outside DONE.
        if (cnt_q == CW'(1)) begin
          state_d     = DONE;
          quotient_d  = q_d;
          remainder_d = r_d[N-1:0];
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      q_q         <= '0;
      d_q         <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      q_q         <= q_d;
      d_q         <= d_d;
      r_q         <= r_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Randomized self-checking bench for seq_restoring_divider against plain integer division.
module tb_seq_restoring_divider;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  int total = 0;
  int bad = 0;

  seq_restoring_divider #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Starts and ends just after a falling edge. stall holds out_ready low that many cycles
  // after out_valid, while presenting na/nb which must be ignored.
  task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b, input int stall,
                               input logic [N-1:0] na, input logic [N-1:0] nb,
                               input logic keepValid);
    int n;
    logic [N-1:0] eq, er;
    logic ed;
    ed = (b == 0);
    eq = ed ? {N{1'b1}} : N'(int'(a) / int'(b));
    er = ed ? a : N'(int'(a) % int'(b));
    dividend  = a;
    divisor   = b;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    checkOutput("accept_wait", (n < 40), 1);
    @(posedge clk);
    #1 if (!keepValid) in_valid = 1'b0;
    n = 1;
    @(negedge clk);
    while (!out_valid && n < 3 * N) begin
      checkOutput("overlap", (out_valid & in_ready), 0);
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    checkOutput("latency", n, ed ? 1 : N + 1);
    checkOutput("quotient", quotient, eq);
    checkOutput("remainder", remainder, er);
    checkOutput("div_by_zero", div_by_zero, ed);
    checkOutput("in_ready_done", in_ready, 0);
    if (stall > 0) begin
      dividend = na;
      divisor  = nb;
      in_valid = 1'b1;
      for (int i = 0; i < stall; i++) begin
        @(posedge clk);
        @(negedge clk);
        checkOutput("stall_valid", out_valid, 1);
        checkOutput("stall_ready", in_ready, 0);
        checkOutput("stall_quotient", quotient, eq);
        checkOutput("stall_remainder", remainder, er);
      end
      out_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    checkOutput("post_valid", out_valid, 0);
    checkOutput("post_ready", in_ready, 1);
    checkOutput("held_quotient", quotient, eq);
    checkOutput("held_dbz", div_by_zero, ed);
  endtask

  task automatic resetMidOp();
    dividend  = 8'd100;
    divisor   = 8'd7;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_quotient", quotient, 0);
    checkOutput("rst_remainder", remainder, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [N-1:0] ra, rb;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dividend  = '0;
    divisor   = '0;
    #12;
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_quotient", quotient, 0);
    checkOutput("reset_remainder", remainder, 0);
    checkOutput("reset_dbz", div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(8'd100, 8'd7, 0, 8'd0, 8'd0, 1'b0);
    applyStimulus(8'd255, 8'd128, 0, 8'd0, 8'd0, 1'b0);
    applyStimulus(8'd255, 8'd1, 0, 8'd0, 8'd0, 1'b0);
    applyStimulus(8'd200, 8'd255, 0, 8'd0, 8'd0, 1'b0);
    applyStimulus(8'd5, 8'd0, 0, 8'd0, 8'd0, 1'b0);
    applyStimulus(8'd100, 8'd7, 5, 8'd9, 8'd3, 1'b0);
    applyStimulus(8'd9, 8'd3, 0, 8'd0, 8'd0, 1'b0);

    resetMidOp();
    applyStimulus(8'd50, 8'd6, 0, 8'd0, 8'd0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      ra = N'($urandom_range(0, 255));
      case (i)
        0: rb = '0;
        1: rb = 8'h80;
        2: begin ra = N'($urandom_range(0, 50)); rb = N'($urandom_range(51, 255)); end
        default: rb = N'($urandom_range(0, 255));
      endcase
      applyStimulus(ra, rb, (i == 4) ? 2 : 0, ra, rb, 1'b1);
    end
    in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
